// File: rtl/capture_gate.sv
// Packet capture gate: forwards or discards whole AXI-Stream packets, optionally
// truncating forwarded packets to snaplen beats, with saturating statistics.
module capture_gate #(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128,
    parameter int SNAPLEN_WIDTH = 8,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                       axi_aclk,
    input  logic                       axi_areset,
    input  logic [C_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    input  logic                       capture_en,
    input  logic [SNAPLEN_WIDTH-1:0]   snaplen,
    input  logic                       clear_stats,
    output logic [CNT_WIDTH-1:0]       pkt_count,
    output logic [CNT_WIDTH-1:0]       drop_count,
    output logic [CNT_WIDTH-1:0]       trunc_count,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, PASS, DROP, TRIM} state_t;

    state_t                    state_reg, state_next;
    logic                      en_q_reg;
    logic [SNAPLEN_WIDTH-1:0]  snap_q_reg;
    logic [SNAPLEN_WIDTH-1:0]  beat_cnt_reg, beat_cnt_next;
    logic                      busy_reg, busy_next;

    logic                      fwd;
    logic                      accept;
    logic                      first_beat;
    logic                      trunc;
    logic                      drop_mode;
    logic [SNAPLEN_WIDTH-1:0]  snap_eff;
    logic [SNAPLEN_WIDTH-1:0]  beat_idx;
    logic [2:0]                stat_inc;
    logic [3*CNT_WIDTH-1:0]    cnt_all;

    // In IDLE the live capture_en/snaplen govern the first beat; afterwards the latched copies.
    always_comb begin
        fwd        = (state_reg == IDLE) ? capture_en : ((state_reg == PASS) && en_q_reg);
        drop_mode  = ((state_reg == IDLE) && !capture_en) || (state_reg == DROP);
        snap_eff   = (state_reg == IDLE) ? snaplen : snap_q_reg;
        beat_idx   = (state_reg == IDLE) ? '0 : beat_cnt_reg;
        trunc      = fwd && (snap_eff != '0) && (beat_idx == snap_eff - SNAPLEN_WIDTH'(1))
                     && !s_axis_tlast;
        accept     = s_axis_tvalid && s_axis_tready;
        first_beat = accept && (state_reg == IDLE);
    end

    assign s_axis_tready = fwd ? m_axis_tready : 1'b1;
    assign m_axis_tvalid = fwd && s_axis_tvalid;
    assign m_axis_tlast  = s_axis_tlast || trunc;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tstrb  = s_axis_tstrb;
    assign m_axis_tuser  = s_axis_tuser;

    // State register
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            en_q_reg     <= 1'b0;
            snap_q_reg   <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            busy_reg     <= busy_next;
            if (first_beat) begin
                en_q_reg   <= capture_en;
                snap_q_reg <= snaplen;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (accept) begin
            if (s_axis_tlast) begin
                state_next = IDLE;
            end else begin
                unique case (state_reg)
                    IDLE:    state_next = !capture_en ? DROP : (trunc ? TRIM : PASS);
                    PASS:    state_next = trunc ? TRIM : PASS;
                    DROP:    state_next = DROP;
                    TRIM:    state_next = TRIM;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Output / counter-update logic
    always_comb begin
        busy_next     = (state_next != IDLE);
        beat_cnt_next = beat_cnt_reg;
        if (first_beat) begin
            beat_cnt_next = fwd ? SNAPLEN_WIDTH'(1) : '0;
        end else if (accept && (state_reg == PASS)) begin
            beat_cnt_next = beat_cnt_reg + SNAPLEN_WIDTH'(1);
        end
    end

    assign stat_inc[0] = accept && fwd && m_axis_tlast;
    assign stat_inc[1] = accept && s_axis_tlast && drop_mode;
    assign stat_inc[2] = accept && trunc;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge axi_aclk or posedge axi_areset) begin
                if (axi_areset) begin
                    cnt_reg <= '0;
                end else if (clear_stats) begin
                    cnt_reg <= '0;
                end else if (stat_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                end
            end
            assign cnt_all[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
        end
    endgenerate

    assign pkt_count   = cnt_all[0*CNT_WIDTH +: CNT_WIDTH];
    assign drop_count  = cnt_all[1*CNT_WIDTH +: CNT_WIDTH];
    assign trunc_count = cnt_all[2*CNT_WIDTH +: CNT_WIDTH];
    assign busy        = busy_reg;

endmodule

// File: tb/tb_capture_gate.sv
// Randomised scoreboard bench for capture_gate: the packet-level model predicts
// egress beats and statistics; a monitor checks every egress handshake.
module tb_capture_gate;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int SW = 4;
    localparam int CW = 4;
    localparam int KW = DW / 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          axi_aclk = 1'b0;
    logic          axi_areset;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tstrb;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic          capture_en, clear_stats, busy;
    logic [SW-1:0] snaplen;
    logic [CW-1:0] pkt_count, drop_count, trunc_count;

    always #5 axi_aclk = ~axi_aclk;

    capture_gate #(
        .C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW), .SNAPLEN_WIDTH(SW), .CNT_WIDTH(CW)
    ) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .capture_en(capture_en), .snaplen(snaplen), .clear_stats(clear_stats),
        .pkt_count(pkt_count), .drop_count(drop_count), .trunc_count(trunc_count), .busy(busy)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    m_pkt = 0, m_drop = 0, m_trunc = 0;
    int    ready_mode = 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int sat_inc(int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Egress backpressure: 0 random, 1 always ready, 2 toggling
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge axi_aclk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'($urandom_range(0, 1));
                2:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    // Monitor: every egress handshake is popped from the scoreboard and compared
    always @(negedge axi_aclk) begin
        if (!axi_areset && m_axis_tvalid) begin
            chk("ready_mirror", 64'(s_axis_tready), 64'(m_axis_tready));
            if (m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat actual=data %0h required=no beat", m_axis_tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("tdata", 64'(m_axis_tdata), 64'(e.d));
                    chk("tstrb", 64'(m_axis_tstrb), 64'(e.k));
                    chk("tuser", 64'(m_axis_tuser), 64'(e.u));
                    chk("tlast", 64'(m_axis_tlast), 64'(e.l));
                    $display("beat out data=%h strb=%h user=%h last=%0b", m_axis_tdata,
                             m_axis_tstrb, m_axis_tuser, m_axis_tlast);
                end
            end
        end
    end

    task automatic drive_beat(beat_t b, bit en, int snap, bit clr);
        int  n;
        bit  acc;
        @(posedge axi_aclk);
        #1;
        s_axis_tdata = b.d;
        s_axis_tstrb = b.k;
        s_axis_tuser = b.u;
        s_axis_tlast = b.l;
        capture_en   = en;
        snaplen      = SW'(snap);
        clear_stats  = clr;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge axi_aclk);
            #1;
        end
        s_axis_tvalid = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge axi_aclk);
            acc = s_axis_tready;
            @(posedge axi_aclk);
            #1;
            if (!acc) begin
                n++;
                if (n > 100) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout actual=%0d cycles required=<=100", n);
                    acc = 1'b1;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        clear_stats   = 1'b0;
    endtask

    task automatic send_packet(int len, bit en, int snap, bit clr_last, bit flip);
        beat_t b[$];
        int    nout;
        for (int i = 0; i < len; i++) begin
            beat_t x;
            x.d = DW'($urandom);
            x.k = KW'($urandom);
            x.u = UW'($urandom);
            x.l = (i == len - 1);
            b.push_back(x);
        end
        nout = (snap == 0 || snap >= len) ? len : snap;
        if (en) begin
            for (int i = 0; i < nout; i++) begin
                beat_t e;
                e = b[i];
                e.l = (i == nout - 1);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < len; i++) begin
            bit en_i;
            int sn_i;
            en_i = (i == 0) ? en : (flip ? !en : 1'($urandom_range(0, 1)));
            sn_i = (i == 0) ? snap : $urandom_range(0, 15);
            drive_beat(b[i], en_i, sn_i, clr_last && (i == len - 1));
            @(negedge axi_aclk);
            chk("busy", 64'(busy), 64'(i != len - 1));
        end
        if (en) begin
            m_pkt = sat_inc(m_pkt);
            if (nout < len) m_trunc = sat_inc(m_trunc);
        end else begin
            m_drop = sat_inc(m_drop);
        end
        if (clr_last) begin
            m_pkt = 0; m_drop = 0; m_trunc = 0;
        end
        chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("trunc_count", 64'(trunc_count), 64'(m_trunc));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("packet len=%0d en=%0b snap=%0d clr=%0b -> pkt=%0d drop=%0d trunc=%0d",
                 len, en, snap, clr_last, pkt_count, drop_count, trunc_count);
    endtask

    task automatic clear_pulse();
        @(posedge axi_aclk);
        #1;
        clear_stats = 1'b1;
        @(posedge axi_aclk);
        #1;
        clear_stats = 1'b0;
        m_pkt = 0; m_drop = 0; m_trunc = 0;
        @(negedge axi_aclk);
        chk("clear_pkt", 64'(pkt_count), 64'(m_pkt));
        chk("clear_drop", 64'(drop_count), 64'(m_drop));
        chk("clear_trunc", 64'(trunc_count), 64'(m_trunc));
        $display("clear_stats pulse -> pkt=%0d drop=%0d trunc=%0d", pkt_count, drop_count, trunc_count);
    endtask

    initial begin
        axi_areset    = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        capture_en    = 1'b0;
        snaplen       = '0;
        clear_stats   = 1'b0;

        @(negedge axi_aclk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_pkt", 64'(pkt_count), 64'd0);
        chk("reset_drop", 64'(drop_count), 64'd0);
        chk("reset_trunc", 64'(trunc_count), 64'd0);
        chk("reset_mvalid", 64'(m_axis_tvalid), 64'd0);
        $display("reset state busy=%0b pkt=%0d", busy, pkt_count);
        @(posedge axi_aclk);
        #1;
        axi_areset = 1'b0;

        // Directed scenarios
        ready_mode = 1;
        send_packet(4, 1'b1, 0, 1'b0, 1'b0);
        send_packet(5, 1'b1, 2, 1'b0, 1'b0);
        send_packet(3, 1'b0, 0, 1'b0, 1'b1);
        send_packet(1, 1'b1, 0, 1'b0, 1'b0);
        send_packet(4, 1'b1, 1, 1'b0, 1'b0);
        send_packet(3, 1'b1, 3, 1'b0, 1'b0);
        send_packet(1, 1'b1, 1, 1'b0, 1'b0);
        send_packet(1, 1'b0, 2, 1'b0, 1'b0);
        ready_mode = 2;
        send_packet(3, 1'b1, 0, 1'b0, 1'b0);
        send_packet(6, 1'b1, 4, 1'b0, 1'b1);

        // Randomised traffic
        ready_mode = 0;
        for (int p = 0; p < 60; p++) begin
            send_packet($urandom_range(1, 8), 1'($urandom_range(0, 1)), $urandom_range(0, 6),
                        ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end

        // Saturation, then clear coinciding with a tlast beat
        ready_mode = 1;
        clear_pulse();
        for (int p = 0; p < CMAX + 2; p++) begin
            send_packet($urandom_range(1, 3), 1'b1, 0, 1'b0, 1'b0);
        end
        chk("pkt_saturated", 64'(pkt_count), 64'(CMAX));
        send_packet(2, 1'b1, 0, 1'b1, 1'b0);
        send_packet(2, 1'b1, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a forwarded packet
        begin
            beat_t rb[2];
            for (int i = 0; i < 2; i++) begin
                rb[i].d = DW'($urandom);
                rb[i].k = KW'($urandom);
                rb[i].u = UW'($urandom);
                rb[i].l = 1'b0;
                exp_q.push_back(rb[i]);
            end
            drive_beat(rb[0], 1'b1, 0, 1'b0);
            drive_beat(rb[1], 1'b1, 0, 1'b0);
            @(negedge axi_aclk);
            chk("busy_before_reset", 64'(busy), 64'd1);
            #1;
            axi_areset = 1'b1;
            #1;
            chk("async_busy", 64'(busy), 64'd0);
            chk("async_pkt", 64'(pkt_count), 64'd0);
            chk("async_drop", 64'(drop_count), 64'd0);
            chk("async_trunc", 64'(trunc_count), 64'd0);
            $display("mid-packet reset busy=%0b pkt=%0d", busy, pkt_count);
            exp_q.delete();
            m_pkt = 0; m_drop = 0; m_trunc = 0;
            @(posedge axi_aclk);
            #1;
            axi_areset = 1'b0;
        end
        send_packet(3, 1'b0, 0, 1'b0, 1'b1);
        send_packet(2, 1'b1, 0, 1'b0, 1'b0);

        repeat (3) @(posedge axi_aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/capture_gate.md
CAPTURE_GATE -- requirements
Module: capture_gate

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 256, stream data width in bits.
REQ-002 SHALL have parameter C_TUSER_WIDTH, default 128, stream tuser width in bits.
REQ-003 SHALL have parameter SNAPLEN_WIDTH, default 8, width of snaplen in beats.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, width of each statistics counter.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 axi_aclk  input  1  clock; all logic on rising edge.
REQ-007 axi_areset  input  1  asynchronous active-high reset.
REQ-008 s_axis_tdata/tstrb/tuser/tvalid/tlast  input  C_DATA_WIDTH / C_DATA_WIDTH/8 / C_TUSER_WIDTH / 1 / 1  ingress stream.
REQ-009 s_axis_tready  output  1  ingress ready.
REQ-010 m_axis_tdata/tstrb/tuser/tvalid/tlast  output  same widths as ingress  egress stream.
REQ-011 m_axis_tready  input  1  egress ready.
REQ-012 capture_en  input  1  forward (1) or discard (0) packets; sampled per packet.
REQ-013 snaplen  input  SNAPLEN_WIDTH  max forwarded beats per packet; 0 = unlimited; sampled per packet.
REQ-014 clear_stats  input  1  synchronous clear of all counters.
REQ-015 pkt_count, drop_count, trunc_count  output  CNT_WIDTH each  forwarded / discarded / truncated packet counts.
REQ-016 busy  output  1  high while state is not IDLE.

Function
REQ-017 SHALL implement states IDLE (packet boundary), PASS (forwarding), DROP (discarding whole packet), TRIM (discarding tail after truncation).
REQ-018 Beat accepted = s_axis_tvalid & s_axis_tready; first beat = beat accepted in IDLE.
REQ-019 On first beat SHALL latch capture_en into en_q and snaplen into snap_q; mid-packet changes of either SHALL have no effect until the next packet.
REQ-020 Forwarding (IDLE with capture_en=1, or PASS): m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, data/tstrb/tuser passed combinationally, latency 0 cycles.
REQ-021 Discarding (IDLE with capture_en=0, DROP, TRIM): s_axis_tready=1, m_axis_tvalid=0.
REQ-022 Beat counter SHALL reset to 0 at each first beat and increment per forwarded beat; width SNAPLEN_WIDTH.
REQ-023 When snap_q!=0 and forwarded beat index == snap_q-1 and s_axis_tlast=0: m_axis_tlast SHALL be forced to 1 on that beat, tstrb unchanged, next state TRIM.
REQ-024 Otherwise m_axis_tlast = s_axis_tlast.
REQ-025 Transitions: IDLE->PASS on forwarded first beat without tlast; IDLE->DROP on discarded first beat without tlast; any state->IDLE on accepted beat with s_axis_tlast=1; PASS->TRIM per REQ-023.
REQ-026 Single-beat packet (first beat with tlast) SHALL be handled entirely in IDLE; state remains IDLE.
REQ-027 snaplen=1 on a multi-beat packet SHALL forward only the first beat with m_axis_tlast=1.
REQ-028 pkt_count SHALL increment once per forwarded packet, on the beat carrying m_axis_tlast=1 accepted downstream.
REQ-029 drop_count SHALL increment on the accepted s_axis_tlast beat of a discarded packet (IDLE-with-tlast or DROP).
REQ-030 trunc_count SHALL increment on the truncating beat of REQ-023.
REQ-031 Counters SHALL saturate at all-ones; clear_stats SHALL take priority over a same-cycle increment.
REQ-032 busy and counters SHALL be registered; datapath outputs SHALL be combinational from inputs and state.

Reset
REQ-033 On axi_areset: state=IDLE, beat counter=0, en_q=0, snap_q=0, all counters=0, busy=0; m_axis_tvalid follows REQ-020/021 from IDLE.
REQ-034 Reset mid-packet SHALL abandon the packet; the next accepted beat after release is treated as a first beat.

Verification
REQ-035 capture_en=1, snaplen=0, 4-beat packet, m_axis_tready=1 -> 4 beats out unchanged, tlast on beat 4, pkt_count=1.
REQ-036 capture_en=1, snaplen=2, 5-beat packet -> 2 beats out, m_axis_tlast=1 on beat 2, beats 3-5 consumed with m_axis_tvalid=0, trunc_count=1, pkt_count=1.
REQ-037 capture_en=0 at first beat, raised to 1 on beat 2 of a 3-beat packet, then 1-beat packet -> first packet fully dropped (drop_count=1), second forwarded (pkt_count=1).
REQ-038 capture_en=1, m_axis_tready toggling 1,0,1,0 during 3-beat packet -> s_axis_tready mirrors m_axis_tready, no beat lost or duplicated, busy high until tlast accepted.
REQ-039 pkt_count preloaded near all-ones by 2^CNT_WIDTH-1 packets (CNT_WIDTH=4 build: 15 packets) then 2 more -> pkt_count stays 15; clear_stats with simultaneous tlast -> pkt_count=0.
REQ-040 axi_areset asserted on beat 2 of 4-beat forwarded packet -> busy=0, counters=0 immediately; next beat after release treated as first beat.
